// File: rtl/bitbang_pkg.sv
// -----------------------------------------------------------------------------
// bitbang_pkg
// Shared definitions for the bit-banged frame controller:
//   - state_t            : frame controller states (HUNT, PAYLOAD, CHECK, HOLD)
//   - DEF_PAYLOAD_BYTES  : default payload bytes per frame
//   - DEF_SYNC_BYTE      : default frame start marker
//   - DEF_TIMEOUT_CYCLES : default allowed clk cycles between received bytes
//   - sat_inc8()         : 8-bit saturating increment used by the error counter
// -----------------------------------------------------------------------------
package bitbang_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam int         DEF_PAYLOAD_BYTES  = 44;
  localparam logic [7:0] DEF_SYNC_BYTE      = 8'hA5;
  localparam int         DEF_TIMEOUT_CYCLES = 1000000;

  // Saturates at 255 so a long run of bad frames never wraps back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/bitbang_timeout.sv
// -----------------------------------------------------------------------------
// bitbang_timeout
// Clearable free-running counter with a terminal-count pulse. The counter
// advances every clock unless cleared; when it sits at TERMINAL-1 and is not
// being cleared on the same cycle, tc is asserted (combinationally) and the
// counter returns to zero on the next edge.
//
// Ports:
//   clk   in  1  rising-edge clock
//   rst   in  1  asynchronous active-high reset, counter to 0
//   clear in  1  synchronous clear, wins over the terminal count
//   tc    out 1  terminal count reached this cycle (one-cycle pulse)
// -----------------------------------------------------------------------------
module bitbang_timeout
  import bitbang_pkg::*;
#(
  parameter int TERMINAL = DEF_TIMEOUT_CYCLES,
  parameter int WIDTH    = $clog2(TERMINAL)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tc
);

  logic [WIDTH-1:0] count;

  // A clear on the terminal cycle suppresses the pulse: a byte that arrives
  // exactly on the deadline still counts as arriving in time.
  assign tc = !clear && (count == WIDTH'(TERMINAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bitbang_frame_ctrl.sv
// -----------------------------------------------------------------------------
// bitbang_frame_ctrl
// Frames a byte stream from a bit-banged receiver. A frame is SYNC_BYTE,
// PAYLOAD_BYTES payload bytes, then one checksum byte equal to the XOR of the
// payload. A good frame is held on work_data until the consumer acknowledges
// it. Bad checksums, bytes arriving while a frame is held (overrun), and
// stalls mid-frame are counted in frame_err_cnt. A stall (no byte for
// TIMEOUT_CYCLES while the receiver is mid-frame or mid-byte) also pulses
// rx_resync to restart the receiver's bit counter.
//
// Ports:
//   clk           in  1                 rising-edge clock
//   rst           in  1                 asynchronous active-high reset
//   rx_ready      in  1                 one-cycle strobe, rx_data valid
//   rx_data       in  8                 received byte
//   rx_idle       in  1                 receiver bit counter at zero
//   rx_resync     out 1                 one-cycle resync pulse to receiver
//   work_valid    out 1                 assembled payload available
//   work_ack      in  1                 consumer accepts payload
//   work_data     out 8*PAYLOAD_BYTES   payload, first byte in [7:0]
//   frame_err_cnt out 8                 saturating frame error count
//
// Handshake: work_valid rises the cycle after a good checksum byte and stays
// high, with work_data frozen, until a cycle where work_ack is sampled high;
// work_valid is low from the following cycle. work_ack while work_valid is
// low has no effect. The receive side has no back-pressure: rx_ready is a
// strobe that is always consumed.
// -----------------------------------------------------------------------------
module bitbang_frame_ctrl
  import bitbang_pkg::*;
#(
  parameter int         PAYLOAD_BYTES  = DEF_PAYLOAD_BYTES,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_ready,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_idle,
  output logic                       rx_resync,
  output logic                       work_valid,
  input  logic                       work_ack,
  output logic [8*PAYLOAD_BYTES-1:0] work_data,
  output logic [7:0]                 frame_err_cnt
);

  localparam int IDX_W = $clog2(PAYLOAD_BYTES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  state_t           state;
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]       checksum;

  logic             sync_hit;
  logic             to_clear;
  logic             to_fire;
  logic             err_inc;

  assign sync_hit = rx_ready && (rx_data == SYNC_BYTE);

  // The watchdog only runs while something is actually in flight: a frame
  // being assembled, or a receiver that has started a byte (rx_idle low) while
  // hunting. Holding a finished frame never times out.
  assign to_clear = rx_ready
                 || (state == ST_HOLD)
                 || ((state == ST_HUNT) && rx_idle);

  bitbang_timeout #(
    .TERMINAL (TIMEOUT_CYCLES),
    .WIDTH    (TO_W)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (to_clear),
    .tc    (to_fire)
  );

  // Error sources are mutually exclusive by construction (the timeout can
  // only fire on a cycle without rx_ready), so at most one increment a cycle.
  always_comb begin
    err_inc = 1'b0;
    if (to_fire) begin
      // A stall while hunting is a stuck receiver, not a lost frame.
      err_inc = (state == ST_PAYLOAD) || (state == ST_CHECK);
    end else if (rx_ready) begin
      unique case (state)
        ST_CHECK: err_inc = (rx_data != checksum);
        ST_HOLD:  err_inc = !work_ack;
        default:  err_inc = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_HUNT;
      byte_idx      <= '0;
      checksum      <= 8'h00;
      rx_resync     <= 1'b0;
      work_valid    <= 1'b0;
      work_data     <= '0;
      frame_err_cnt <= 8'h00;
    end else begin
      rx_resync <= 1'b0;

      if (err_inc) begin
        frame_err_cnt <= sat_inc8(frame_err_cnt);
      end

      if (to_fire) begin
        // Abandon whatever was in progress and restart the receiver.
        state      <= ST_HUNT;
        rx_resync  <= 1'b1;
        work_valid <= 1'b0;
      end else begin
        unique case (state)
          ST_HUNT: begin
            if (sync_hit) begin
              state    <= ST_PAYLOAD;
              byte_idx <= '0;
              checksum <= 8'h00;
            end
          end

          ST_PAYLOAD: begin
            if (rx_ready) begin
              for (int b = 0; b < PAYLOAD_BYTES; b++) begin
                if (byte_idx == IDX_W'(b)) begin
                  work_data[b*8 +: 8] <= rx_data;
                end
              end
              checksum <= checksum ^ rx_data;
              byte_idx <= byte_idx + IDX_W'(1);
              if (byte_idx == IDX_W'(PAYLOAD_BYTES - 1)) begin
                state <= ST_CHECK;
              end
            end
          end

          ST_CHECK: begin
            if (rx_ready) begin
              if (rx_data == checksum) begin
                state      <= ST_HOLD;
                work_valid <= 1'b1;
              end else begin
                state <= ST_HUNT;
              end
            end
          end

          ST_HOLD: begin
            // Without an ack any incoming byte is an overrun and is dropped
            // (counted above). With an ack the byte is seen as a hunt byte,
            // so back-to-back frames do not lose their sync marker.
            if (work_ack) begin
              work_valid <= 1'b0;
              if (sync_hit) begin
                state    <= ST_PAYLOAD;
                byte_idx <= '0;
                checksum <= 8'h00;
              end else begin
                state <= ST_HUNT;
              end
            end
          end

          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule
